// File: rtl/serial_count_tx.sv
// Parallel-to-serial frame transmitter: shifts WIDTH bits LSB first on a divided
// serial clock, then emits a one-cycle load/done strobe for the receiver.
module serial_count_tx #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             sclk,
    output logic             sdo,
    output logic             load,
    output logic             busy,
    output logic             done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LOAD
    } state_t;

    state_t           r_state,   w_state;
    logic [WIDTH-1:0] r_shreg,   w_shreg;
    logic [BIT_W-1:0] r_bit_cnt, w_bit_cnt;
    logic [DIV_W-1:0] r_div_cnt, w_div_cnt;
    logic             r_sclk,    w_sclk;
    logic             r_sdo,     w_sdo;
    logic             r_load,    w_load;
    logic             r_busy,    w_busy;
    logic             r_done,    w_done;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
            r_sdo     <= 1'b0;
            r_load    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (ena) begin
            r_state   <= w_state;
            r_shreg   <= w_shreg;
            r_bit_cnt <= w_bit_cnt;
            r_div_cnt <= w_div_cnt;
            r_sclk    <= w_sclk;
            r_sdo     <= w_sdo;
            r_load    <= w_load;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state   = r_state;
        w_shreg   = r_shreg;
        w_bit_cnt = r_bit_cnt;
        w_div_cnt = r_div_cnt;
        w_sclk    = r_sclk;
        w_sdo     = r_sdo;
        w_load    = 1'b0;
        w_done    = 1'b0;
        w_busy    = r_busy;

        unique case (r_state)
            S_IDLE: begin
                w_sclk = 1'b0;
                w_sdo  = 1'b0;
                w_busy = 1'b0;
                if (start) begin
                    w_state   = S_SHIFT;
                    w_shreg   = data;
                    w_bit_cnt = '0;
                    w_div_cnt = '0;
                    w_sdo     = data[0];
                    w_busy    = 1'b1;
                end
            end

            S_SHIFT: begin
                w_sdo = r_shreg[0];
                if (r_div_cnt != DIV_LAST) begin
                    w_div_cnt = r_div_cnt + DIV_W'(1);
                end else begin
                    w_div_cnt = '0;
                    if (!r_sclk) begin
                        w_sclk = 1'b1;
                    end else begin
                        // End of the high phase: retire this bit and present the next one.
                        w_sclk  = 1'b0;
                        w_shreg = {1'b0, r_shreg[WIDTH-1:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state = S_LOAD;
                            w_sdo   = 1'b0;
                            w_load  = 1'b1;
                            w_done  = 1'b1;
                        end else begin
                            w_bit_cnt = r_bit_cnt + BIT_W'(1);
                            w_sdo     = r_shreg[1];
                        end
                    end
                end
            end

            S_LOAD: begin
                w_state = S_IDLE;
                w_sclk  = 1'b0;
                w_sdo   = 1'b0;
                w_busy  = 1'b0;
            end

            default: begin
                w_state = S_IDLE;
                w_sclk  = 1'b0;
                w_sdo   = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign sclk = r_sclk;
    assign sdo  = r_sdo;
    assign load = r_load;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_serial_count_tx.sv
// Directed bench for serial_count_tx: default 8-bit/div-2 instance plus a
// 4-bit/div-1 instance, with a per-cycle monitor and an MSB-insert receiver model.
module tb_serial_count_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena_a, start_a, ena_b, start_b;
    logic [7:0] data_a;
    logic [3:0] data_b;
    logic       sclk_a, sdo_a, load_a, busy_a, done_a;
    logic       sclk_b, sdo_b, load_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    int          cyc, load_at, load_cnt, done_at, done_cnt, busy_cnt, first_busy, nbits, tog, frz_bad;
    logic [15:0] bits;
    logic [7:0]  rx, rx_at_load;
    logic        prev_sclk;
    logic [4:0]  snap;
    logic        m_sclk, m_sdo, m_load, m_busy, m_done;

    serial_count_tx u_dut_a (
        .clk(clk), .rst(rst), .ena(ena_a), .start(start_a), .data(data_a),
        .sclk(sclk_a), .sdo(sdo_a), .load(load_a), .busy(busy_a), .done(done_a)
    );

    serial_count_tx #(.WIDTH(4), .CLK_DIV(1)) u_dut_b (
        .clk(clk), .rst(rst), .ena(ena_b), .start(start_b), .data(data_b),
        .sclk(sclk_b), .sdo(sdo_b), .load(load_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; load_at = 0; load_cnt = 0; done_at = 0; done_cnt = 0;
        busy_cnt = 0; first_busy = 0; nbits = 0; tog = 0;
        bits = '0; rx = '0; rx_at_load = '0; prev_sclk = 1'b0;
    endtask

    // One clock, then sample the selected instance on the falling edge.
    task automatic tick(input bit sel);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        m_sclk = sel ? sclk_b : sclk_a;
        m_sdo  = sel ? sdo_b  : sdo_a;
        m_load = sel ? load_b : load_a;
        m_busy = sel ? busy_b : busy_a;
        m_done = sel ? done_b : done_a;
        if (m_load) begin load_cnt++; load_at = cyc; rx_at_load = rx; end
        if (m_done) begin done_cnt++; done_at = cyc; end
        if (m_busy) begin busy_cnt++; if (first_busy == 0) first_busy = cyc; end
        if (m_sclk !== prev_sclk) tog++;
        if (m_sclk === 1'b1 && prev_sclk === 1'b0) begin
            if (nbits < 16) bits[nbits] = m_sdo;
            nbits++;
            rx = {m_sdo, rx[7:1]};
        end
        prev_sclk = m_sclk;
    endtask

    task automatic launch_a(input logic [7:0] d);
        clear_mon();
        data_a  = d;
        start_a = 1'b1;
        tick(0);
        start_a = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena_a = 1'b1; ena_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_a", {sclk_a, sdo_a, load_a, busy_a, done_a}, 0);
        chk("reset_outputs_b", {sclk_b, sdo_b, load_b, busy_b, done_b}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xA5 frame at defaults: LSB-first bits 1,0,1,0,0,1,0,1.
        launch_a(8'hA5);
        while (cyc < 40) tick(0);
        chk("a5_bits", bits[7:0], 8'hA5);
        chk("a5_nbits", nbits, 8);
        chk("a5_load_cycle", load_at, 33);
        chk("a5_load_count", load_cnt, 1);
        chk("a5_done_cycle", done_at, 33);
        chk("a5_done_count", done_cnt, 1);
        chk("a5_busy_first", first_busy, 1);
        chk("a5_busy_cycles", busy_cnt, 33);

        // Loopback into the receiver model.
        launch_a(8'h3C);
        while (cyc < 40) tick(0);
        chk("loop_rx_at_load", rx_at_load, 8'h3C);
        chk("loop_load_cycle", load_at, 33);

        // start with new data during a frame is ignored and not queued.
        launch_a(8'h12);
        while (cyc < 5) tick(0);
        data_a  = 8'hFF;
        start_a = 1'b1;
        while (cyc < 12) tick(0);
        start_a = 1'b0;
        while (cyc < 70) tick(0);
        chk("busy_start_bits", bits[7:0], 8'h12);
        chk("busy_start_nbits", nbits, 8);
        chk("busy_start_loads", load_cnt, 1);
        chk("busy_start_busy", busy_cnt, 33);

        // ena low for 5 cycles after the third sclk rise.
        launch_a(8'h5A);
        while (nbits < 3 && cyc < 40) tick(0);
        chk("ena_third_rise_cycle", cyc, 11);
        snap  = {sclk_a, sdo_a, busy_a, load_a, done_a};
        ena_a = 1'b0;
        frz_bad = 0;
        repeat (5) begin
            tick(0);
            if ({sclk_a, sdo_a, busy_a, load_a, done_a} !== snap) frz_bad++;
        end
        ena_a = 1'b1;
        chk("ena_frozen_cycles_bad", frz_bad, 0);
        while (cyc < 45) tick(0);
        chk("ena_load_cycle", load_at, 38);
        chk("ena_load_count", load_cnt, 1);
        chk("ena_bits", bits[7:0], 8'h5A);
        chk("ena_busy_cycles", busy_cnt, 38);

        // start while ena is low is ignored.
        clear_mon();
        ena_a = 1'b0; start_a = 1'b1; data_a = 8'h81;
        tick(0); tick(0);
        start_a = 1'b0; ena_a = 1'b1;
        repeat (5) tick(0);
        chk("ena_low_start_busy", busy_cnt, 0);

        // Reset in cycle 10 of a frame aborts it without a load pulse.
        launch_a(8'h77);
        while (cyc < 10) tick(0);
        chk("pre_rst_busy_sclk_sdo", {busy_a, sclk_a, sdo_a}, 3'b101);
        rst = 1'b1;
        tick(0);
        rst = 1'b0;
        chk("post_rst_outputs", {sclk_a, sdo_a, busy_a, load_a, done_a}, 0);
        while (cyc < 45) tick(0);
        chk("abort_load_count", load_cnt, 0);
        launch_a(8'h01);
        while (cyc < 40) tick(0);
        chk("after_rst_bits", bits[7:0], 8'h01);
        chk("after_rst_load_cycle", load_at, 33);
        chk("after_rst_load_count", load_cnt, 1);

        // CLK_DIV=1, WIDTH=4 instance: sclk toggles every clk, bits 1,0,0,1.
        clear_mon();
        data_b  = 4'h9;
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        data_b  = 4'h0;
        while (cyc < 14) tick(1);
        chk("b_bits", bits[3:0], 4'b1001);
        chk("b_nbits", nbits, 4);
        chk("b_load_cycle", load_at, 9);
        chk("b_done_cycle", done_at, 9);
        chk("b_sclk_toggles", tog, 8);
        chk("b_busy_cycles", busy_cnt, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
